// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
//   Session controller for an external Mealy "101" detector (overlapping).
//   A session is started from IDLE, clears the detector and the counters for
//   one cycle, then streams up to frame_len bits into the detector while
//   counting hits. A session ends when the frame is exhausted, when the hit
//   target is reached (if one is set), or on abort (no done pulse).
//
// Ports
//   clk          in   system clock, rising-edge active
//   reset        in   asynchronous active-high reset
//   start        in   session start request, only sampled in IDLE
//   abort        in   terminates an active session (CLEAR/SCAN)
//   frame_len    in   [7:0] number of bits to scan, latched on start
//   hit_target   in   [3:0] early-exit hit count, latched on start; 0 = none
//   x_in         in   serial stream, one bit per clock
//   det_hit      in   combinational hit from the attached detector
//   det_x        out  bit forwarded to the detector (0 outside SCAN)
//   det_clr      out  detector clear, high in IDLE and CLEAR
//   busy         out  high in CLEAR and SCAN
//   done         out  one-cycle completion pulse
//   found        out  target reached in the last completed session
//   hit_count    out  [3:0] hits in current/last session, saturating at 15
//   bit_count    out  [7:0] bits scanned in current/last session
// -----------------------------------------------------------------------------
module seq_det_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] frame_len,
  input  logic [3:0] hit_target,
  input  logic       x_in,
  input  logic       det_hit,
  output logic       det_x,
  output logic       det_clr,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [3:0] hit_count,
  output logic [7:0] bit_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_frame_len;
  logic [3:0] r_hit_target;
  logic [7:0] r_bit_count;
  logic [3:0] r_hit_count;
  logic       r_found;

  logic [7:0] w_bit_next;
  logic [3:0] w_hit_next;
  logic       w_last_bit;
  logic       w_target_hit;

  // Next-state and per-cycle scan arithmetic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit_count + 8'd1;
    w_hit_next   = r_hit_count;
    if (det_hit && (r_hit_count != 4'd15)) begin
      w_hit_next = r_hit_count + 4'd1;
    end
    w_last_bit   = (w_bit_next == r_frame_len);
    // The target can only be crossed on a hit cycle; once crossed the session
    // has already ended, so >= and == are equivalent here.
    w_target_hit = (r_hit_target != 4'd0) && (w_hit_next >= r_hit_target);

    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (abort)                    w_state_next = S_IDLE;
        else if (r_frame_len == 8'd0) w_state_next = S_DONE;
        else                          w_state_next = S_SCAN;
      end
      S_SCAN: begin
        // Abort has priority over both completion conditions.
        if (abort)                          w_state_next = S_IDLE;
        else if (w_last_bit || w_target_hit) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_frame_len  <= 8'd0;
      r_hit_target <= 4'd0;
      r_bit_count  <= 8'd0;
      r_hit_count  <= 4'd0;
      r_found      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_frame_len  <= frame_len;
            r_hit_target <= hit_target;
          end
        end
        S_CLEAR: begin
          r_found <= 1'b0;
          // An abort here leaves the previous counter values untouched.
          if (!abort) begin
            r_bit_count <= 8'd0;
            r_hit_count <= 4'd0;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_found <= 1'b0;
          end else begin
            r_bit_count <= w_bit_next;
            r_hit_count <= w_hit_next;
            // found is resolved on entry to DONE so it is valid with the pulse.
            if (w_last_bit || w_target_hit) r_found <= w_target_hit;
          end
        end
        default: ;
      endcase
    end
  end

  assign det_x     = (r_state == S_SCAN) && x_in;
  assign det_clr   = (r_state == S_IDLE) || (r_state == S_CLEAR);
  assign busy      = (r_state == S_CLEAR) || (r_state == S_SCAN);
  assign done      = (r_state == S_DONE);
  assign found     = r_found;
  assign hit_count = r_hit_count;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
//   Self-checking bench for seq_det_ctrl. A behavioural overlapping "101"
//   Mealy detector is attached to det_x/det_clr/det_hit. Expected session
//   results are queued when a session is launched and compared when done
//   is observed. Inputs change 1 time unit after the rising edge; outputs
//   are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] frame_len;
  logic [3:0] hit_target;
  logic       x_in;
  logic       det_hit;
  logic       det_x;
  logic       det_clr;
  logic       busy;
  logic       done;
  logic       found;
  logic [3:0] hit_count;
  logic [7:0] bit_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         lat;
    logic [3:0] hit;
    logic [7:0] bits;
    logic       fnd;
  } exp_t;

  exp_t sb[$];

  seq_det_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .frame_len  (frame_len),
    .hit_target (hit_target),
    .x_in       (x_in),
    .det_hit    (det_hit),
    .det_x      (det_x),
    .det_clr    (det_clr),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .hit_count  (hit_count),
    .bit_count  (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference detector: 0 = nothing, 1 = seen "1", 2 = seen "10".
  logic [1:0] d_st;
  logic       force_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        d_st <= 2'd0;
    else if (det_clr) d_st <= 2'd0;
    else if (det_x)   d_st <= 2'd1;
    else              d_st <= (d_st == 2'd1) ? 2'd2 : 2'd0;
  end

  assign det_hit = (det_x && (d_st == 2'd2)) || force_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_session(input string name, input logic [7:0] fl, input logic [3:0] tg,
                             input logic [63:0] bits, input int lat, input logic [3:0] eh,
                             input logic [7:0] eb, input logic ef);
    exp_t e;
    int   cyc;
    bit   seen;
    e.lat = lat; e.hit = eh; e.bits = eb; e.fnd = ef;
    sb.push_back(e);
    start = 1'b1; frame_len = fl; hit_target = tg; x_in = 1'b0;
    @(posedge clk); #1;
    // Config inputs are scrambled after start to prove they were latched.
    start = 1'b0; frame_len = 8'd1; hit_target = 4'd1;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      if (cyc >= 2 && cyc - 2 < 64) x_in = bits[6'(cyc - 2)];
      else                          x_in = 1'b0;
      @(negedge clk);
      if (cyc == 1) begin
        check({name, " clear_busy"}, 32'(busy), 32'd1);
        check({name, " clear_det_clr"}, 32'(det_clr), 32'd1);
      end
      if (cyc == 2 && fl != 8'd0) begin
        check({name, " scan_det_x"}, 32'(det_x), 32'(bits[0]));
        check({name, " scan_det_clr"}, 32'(det_clr), 32'd0);
      end
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      check({name, " latency"}, 32'(cyc), 32'(e.lat));
      check({name, " hit_count"}, 32'(hit_count), 32'(e.hit));
      check({name, " bit_count"}, 32'(bit_count), 32'(e.bits));
      check({name, " found"}, 32'(found), 32'(e.fnd));
      @(posedge clk); #1;
      x_in = 1'b0;
      @(negedge clk);
      check({name, " done_one_cycle"}, 32'(done), 32'd0);
      check({name, " found_hold"}, 32'(found), 32'(e.fnd));
      check({name, " idle_busy"}, 32'(busy), 32'd0);
    end
    frame_len = 8'd0; hit_target = 4'd0; x_in = 1'b0;
    @(posedge clk); #1;
  endtask

  // Starts a 20-bit count-only session on "10"-repeated data and drives bits
  // 1..6; returns just after the edge that begins the cycle after bit 6.
  task automatic scan_six_bits();
    logic [63:0] pat;
    pat = {32{2'b01}};
    start = 1'b1; frame_len = 8'd20; hit_target = 4'd0;
    @(posedge clk); #1;
    start = 1'b0; frame_len = 8'd0;
    for (int c = 2; c <= 7; c++) begin
      @(posedge clk); #1;
      x_in  = pat[6'(c - 2)];
      start = (c == 3);   // start inside a session must be ignored
    end
    @(posedge clk); #1;
    start = 1'b0;
    x_in  = pat[6];
  endtask

  initial begin
    logic [63:0] s101;
    bit          saw_done;
    reset = 1'b1; start = 1'b0; abort = 1'b0; frame_len = 8'd0;
    hit_target = 4'd0; x_in = 1'b0; force_hit = 1'b0;
    s101 = 64'b10110101;

    #3;
    check("rst det_x", 32'(det_x), 32'd0);
    check("rst det_clr", 32'(det_clr), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst found", 32'(found), 32'd0);
    check("rst hit_count", 32'(hit_count), 32'd0);
    check("rst bit_count", 32'(bit_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // IDLE: stream input is not forwarded, abort is ignored.
    x_in = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("idle det_x", 32'(det_x), 32'd0);
    @(posedge clk); #1;
    x_in = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle abort_ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;

    run_session("early_exit", 8'd8, 4'd2, s101, 7, 4'd2, 8'd5, 1'b1);
    run_session("count_only", 8'd8, 4'd0, s101, 10, 4'd3, 8'd8, 1'b0);
    run_session("saturate", 8'd64, 4'd0, {32{2'b01}}, 66, 4'd15, 8'd64, 1'b0);
    run_session("last_bit_target", 8'd3, 4'd1, 64'b101, 5, 4'd1, 8'd3, 1'b1);
    // Forced det_hit outside SCAN must not be counted; found must be cleared.
    force_hit = 1'b1;
    run_session("zero_len", 8'd0, 4'd3, 64'd0, 2, 4'd0, 8'd0, 1'b0);
    force_hit = 1'b0;
    run_session("found_again", 8'd3, 4'd1, 64'b101, 5, 4'd1, 8'd3, 1'b1);

    // Abort after bit 6: the abort cycle's bit would be a hit and must not count.
    scan_six_bits();
    abort = 1'b1;
    @(negedge clk);
    check("abort_cycle busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0; x_in = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (i == 0) check("abort busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    check("abort no_done", 32'(saw_done), 32'd0);
    check("abort bit_count", 32'(bit_count), 32'd6);
    check("abort hit_count", 32'(hit_count), 32'd2);
    check("abort found", 32'(found), 32'd0);

    // Reset after bit 6: immediate return to reset values, no done pulse.
    scan_six_bits();
    reset = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst det_clr", 32'(det_clr), 32'd1);
    check("midrst det_x", 32'(det_x), 32'd0);
    check("midrst found", 32'(found), 32'd0);
    check("midrst hit_count", 32'(hit_count), 32'd0);
    check("midrst bit_count", 32'(bit_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; x_in = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst no_session", 32'(saw_done), 32'd0);

    run_session("after_reset", 8'd8, 4'd2, s101, 7, 4'd2, 8'd5, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide port start  input  1  session start request, sampled in IDLE only.
REQ-004 SHALL provide port abort  input  1  terminates an active session.
REQ-005 SHALL provide port frame_len  input  8  number of stream bits to scan, latched on accepted start.
REQ-006 SHALL provide port hit_target  input  4  hit count ending the session early, latched on accepted start; 0 = count-only.
REQ-007 SHALL provide port x_in  input  1  serial stream, one bit per clock.
REQ-008 SHALL provide port det_hit  input  1  combinational hit from the attached Mealy "101" detector, overlapping.
REQ-009 SHALL provide port det_x  output  1  bit forwarded to the detector.
REQ-010 SHALL provide port det_clr  output  1  reset drive to the detector, active-high.
REQ-011 SHALL provide port busy  output  1  high in CLEAR and SCAN.
REQ-012 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-013 SHALL provide port found  output  1  target reached in last completed session.
REQ-014 SHALL provide port hit_count  output  4  hits in current/last session.
REQ-015 SHALL provide port bit_count  output  8  bits scanned in current/last session.

Function
REQ-016 SHALL implement states IDLE, CLEAR, SCAN, DONE.
REQ-017 IDLE: start=1 -> CLEAR, latch frame_len/hit_target; otherwise stay.
REQ-018 CLEAR: one cycle; hit_count, bit_count, found cleared; -> SCAN, or -> DONE if latched frame_len=0.
REQ-019 SCAN: each cycle det_x=x_in, bit_count+1; if det_hit=1 same cycle, hit_count+1.
REQ-020 hit_count SHALL saturate at 15; bit_count cannot overflow (max 255).
REQ-021 SCAN -> DONE after cycle in which bit_count becomes frame_len.
REQ-022 SCAN -> DONE early in cycle hit_count becomes hit_target when hit_target!=0.
REQ-023 DONE: done=1 for exactly one cycle; found=1 iff hit_target!=0 and hit_count>=hit_target; -> IDLE.
REQ-024 found, hit_count, bit_count SHALL hold in IDLE until next accepted start.
REQ-025 det_x=0 outside SCAN; det_clr=1 in IDLE and CLEAR, 0 in SCAN and DONE.
REQ-026 det_hit SHALL be ignored outside SCAN.
REQ-027 abort=1 in CLEAR or SCAN -> IDLE next cycle, no done pulse, found=0, counters hold values.
REQ-028 abort and final bit/target in same cycle: abort wins.
REQ-029 final bit and target reached in same cycle: single DONE, found=1.
REQ-030 start outside IDLE ignored; abort in IDLE/DONE ignored.
REQ-031 Latency: start accepted cycle 0 -> CLEAR cycle 1 -> first bit cycle 2 -> done at cycle frame_len+2 (no early exit).

Reset
REQ-032 reset=1 SHALL immediately force IDLE, det_x=0, det_clr=1, busy=0, done=0, found=0, hit_count=0, bit_count=0, latched config=0.
REQ-033 Reset mid-session SHALL discard the session with no done pulse.

Verification
REQ-034 frame_len=8, hit_target=2, bits 1,0,1,0,1,1,0,1 -> hits at bits 3,5; done after bit 5, found=1, hit_count=2, bit_count=5.
REQ-035 Same stream, hit_target=0 -> done 10 cycles after start, found=0, hit_count=3, bit_count=8.
REQ-036 frame_len=64, hit_target=0, "10" repeated -> 31 raw hits, hit_count=15 (saturated), bit_count=64, found=0.
REQ-037 frame_len=0, start -> CLEAR, DONE, done pulse at cycle 2, hit_count=0, bit_count=0, found=0.
REQ-038 frame_len=20, abort after bit 6 -> IDLE, no done, bit_count=6; reset after bit 6 instead -> all outputs 0, det_clr=1.
REQ-039 hit_target=1, hit coinciding with last bit of frame_len=3 (bits 1,0,1) -> single done, found=1, hit_count=1, bit_count=3.
